// File: rtl/uart_bus_arbiter_rr.sv
// N-requester bus arbiter: round-robin or fixed-priority winner selection, per-requester
// accept masking, optional grant tenure limit and a one-cycle turnaround between owners.
module uart_bus_arbiter_rr #(
    parameter int NUM_REQ    = 4,
    parameter int MODE       = 0,
    parameter int MAX_TENURE = 16,
    parameter int ID_W       = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] accept_mask,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic               tenure_expired,
    output logic [15:0]        busy_cycles
);

    localparam int CNT_W = $clog2(MAX_TENURE + 2);
    localparam logic [CNT_W-1:0] TENURE_LIMIT = CNT_W'(MAX_TENURE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               gnt_valid_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic [ID_W-1:0]    ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               expired_q;
    logic [15:0]        busy_q;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] excl_mask;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] win_onehot;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    ptr_d;
    logic [ID_W-1:0]    idx;
    logic               found;
    logic               rel_req;
    logic               rel_tenure;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch can be inferred.
        eligible   = req & accept_mask;
        excl_mask  = '0;
        win_onehot = '0;
        winner     = '0;
        idx        = '0;
        found      = 1'b0;

        // An owner just cut off by the tenure limit yields to any other eligible requester.
        if (state_q == GAP && expired_q) begin
            excl_mask[gnt_id_q] = 1'b1;
        end
        cand = ((eligible & ~excl_mask) != '0) ? (eligible & ~excl_mask) : eligible;

        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (MODE == 0) ? ID_W'((int'(ptr_q) + i) % NUM_REQ) : ID_W'(i);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        win_onehot[winner] = found;

        ptr_d      = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        rel_req    = !req[gnt_id_q] || !accept_mask[gnt_id_q];
        rel_tenure = (MAX_TENURE != 0) && (cnt_q == TENURE_LIMIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            expired_q   <= 1'b0;
            busy_q      <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
            expired_q <= 1'b0;
            if (gnt_valid_q && busy_q != 16'hFFFF) begin
                busy_q <= busy_q + 16'd1;
            end

            case (state_q)
                IDLE, GAP: begin
                    if (found) begin
                        state_q     <= GRANT;
                        gnt_q       <= win_onehot;
                        gnt_valid_q <= 1'b1;
                        gnt_id_q    <= winner;
                        cnt_q       <= CNT_W'(1);
                        if (MODE == 0) begin
                            ptr_q <= ptr_d;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (rel_req || rel_tenure) begin
                        state_q     <= GAP;
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        expired_q   <= !rel_req;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt            = gnt_q;
    assign gnt_valid      = gnt_valid_q;
    assign gnt_id         = gnt_id_q;
    assign tenure_expired = expired_q;
    assign busy_cycles    = busy_q;

    a_inputs_known: assert property (@(posedge clock) disable iff (reset)
        !$isunknown({req, accept_mask}));

    a_grant_onehot: assert property (@(posedge clock) disable iff (reset)
        $onehot0(gnt_q) && (gnt_valid_q == |gnt_q));

endmodule

// File: tb/tb_uart_bus_arbiter_rr.sv
// Directed bench for uart_bus_arbiter_rr: a round-robin unlimited-tenure instance and a
// fixed-priority instance with a tenure limit of 4, sharing clock and reset.
module tb_uart_bus_arbiter_rr;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] req_a, mask_a, req_b, mask_b;
    logic [N-1:0] gnt_a, gnt_b;
    logic         gv_a, gv_b;
    logic [1:0]   id_a, id_b;
    logic         te_a, te_b;
    logic [15:0]  busy_a, busy_b;
    logic [1:0]   own;
    int           checks = 0;
    int           errors = 0;

    always #5 clock = ~clock;

    uart_bus_arbiter_rr #(.NUM_REQ(N), .MODE(0), .MAX_TENURE(0)) dut_a (
        .clock          (clock),
        .reset          (reset),
        .req            (req_a),
        .accept_mask    (mask_a),
        .gnt            (gnt_a),
        .gnt_valid      (gv_a),
        .gnt_id         (id_a),
        .tenure_expired (te_a),
        .busy_cycles    (busy_a)
    );

    uart_bus_arbiter_rr #(.NUM_REQ(N), .MODE(1), .MAX_TENURE(4)) dut_b (
        .clock          (clock),
        .reset          (reset),
        .req            (req_b),
        .accept_mask    (mask_b),
        .gnt            (gnt_b),
        .gnt_valid      (gv_b),
        .gnt_id         (id_b),
        .tenure_expired (te_b),
        .busy_cycles    (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        req_a  = '0;
        mask_a = '1;
        req_b  = '0;
        mask_b = '1;
        tick();
        tick();

        check("rst_gnt",    32'(gnt_a),  32'h0);
        check("rst_valid",  32'(gv_a),   32'h0);
        check("rst_id",     32'(id_a),   32'h0);
        check("rst_expire", 32'(te_a),   32'h0);
        check("rst_busy",   32'(busy_a), 32'h0);
        check("rst_gnt_b",  32'(gnt_b),  32'h0);
        reset = 1'b0;
        tick();

        // Round-robin: every owner holds three cycles, drops, then re-raises.
        req_a = 4'hF;
        tick();
        for (int k = 0; k < 5; k++) begin
            own = 2'(k % 4);
            check("rr_gnt", 32'(gnt_a), 32'd1 << own);
            check("rr_id",  32'(id_a),  32'(own));
            tick();
            tick();
            check("rr_hold", 32'(gnt_a), 32'd1 << own);
            req_a[own] = 1'b0;
            tick();
            check("rr_gap",    32'(gv_a), 32'h0);
            check("rr_gap_id", 32'(id_a), 32'(own));
            req_a[own] = 1'b1;
            tick();
        end
        check("rr_busy", 32'(busy_a), 32'd15);
        check("rr_wrap", 32'(id_a),   32'd1);

        // Accept masking and revoke.
        req_a = '0;
        tick();
        tick();
        mask_a = 4'b1101;
        req_a  = 4'b0010;
        tick();
        tick();
        check("mask_decline", 32'(gv_a), 32'h0);
        mask_a = 4'hF;
        tick();
        check("mask_accept", 32'(gnt_a), 32'h2);
        tick();
        mask_a[1] = 1'b0;
        tick();
        check("revoke_gnt",       32'(gnt_a), 32'h0);
        check("revoke_no_expire", 32'(te_a),  32'h0);
        tick();
        check("revoke_stay", 32'(gv_a), 32'h0);
        req_a  = '0;
        mask_a = 4'hF;

        // Fixed priority: no preemption, lowest pending index wins afterwards.
        req_b = 4'b1010;
        tick();
        check("prio_first", 32'(gnt_b), 32'h2);
        req_b = 4'b1011;
        tick();
        check("prio_no_preempt", 32'(gnt_b), 32'h2);
        req_b = 4'b1001;
        tick();
        check("prio_gap",       32'(gnt_b), 32'h0);
        check("prio_no_expire", 32'(te_b),  32'h0);
        req_b = 4'b1011;
        tick();
        check("prio_low_first", 32'(gnt_b), 32'h1);
        req_b = 4'b1010;
        tick();
        check("prio_gap2", 32'(gnt_b), 32'h0);
        tick();
        check("prio_then_1", 32'(gnt_b), 32'h2);
        req_b = 4'b1000;
        tick();
        tick();
        check("prio_then_3", 32'(gnt_b), 32'h8);
        req_b = '0;
        tick();
        tick();

        // Tenure limit with a single requester: expire, gap, re-grant.
        req_b = 4'b0100;
        tick();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                check("ten_hold",      32'(gnt_b), 32'h4);
                check("ten_no_expire", 32'(te_b),  32'h0);
                tick();
            end
            check("ten_release", 32'(gnt_b), 32'h0);
            check("ten_pulse",   32'(te_b),  32'h1);
            tick();
        end
        check("ten_regrant", 32'(gnt_b), 32'h4);
        tick();
        tick();
        tick();
        check("ten_last_cycle", 32'(gnt_b), 32'h4);
        req_b = '0;
        tick();
        check("ten_coincide_gnt",   32'(gnt_b), 32'h0);
        check("ten_coincide_pulse", 32'(te_b),  32'h0);
        tick();

        // Tenure limit with two requesters: expired owner yields.
        req_b = 4'b0101;
        tick();
        for (int c = 0; c < 4; c++) begin
            check("alt_hold0", 32'(gnt_b), 32'h1);
            tick();
        end
        check("alt_pulse0", 32'(te_b), 32'h1);
        check("alt_id0",    32'(id_b), 32'h0);
        tick();
        for (int c = 0; c < 4; c++) begin
            check("alt_hold2", 32'(gnt_b), 32'h4);
            tick();
        end
        check("alt_pulse2", 32'(te_b), 32'h1);
        tick();
        check("alt_back0", 32'(gnt_b), 32'h1);
        req_b = '0;
        tick();
        tick();

        // Asynchronous reset in the middle of a grant.
        req_a = 4'hF;
        tick();
        check("pre_reset_gnt", 32'(gnt_a), 32'h4);
        tick();
        reset = 1'b1;
        #1;
        check("async_gnt",   32'(gnt_a),  32'h0);
        check("async_valid", 32'(gv_a),   32'h0);
        check("async_busy",  32'(busy_a), 32'h0);
        #2;
        reset = 1'b0;
        tick();
        check("post_reset_gnt", 32'(gnt_a), 32'h1);
        check("post_reset_id",  32'(id_a),  32'h0);
        tick();
        check("post_reset_busy", 32'(busy_a), 32'd1);
        req_a = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
